// File: rtl/zion_bitmap_ser_pkg.sv
// ---------------------------------------------------------------------------
// Package: zion_bitmap_ser_pkg
// Purpose: Shared types and helpers for the bitmap -> one-hot serializer.
//   - ser_state_e : serializer state (IDLE = no residue, BUSY = residue left)
//   - onehot2idx  : binary index of a one-hot vector (up to MAX_W bits)
//   - popcnt_le1  : true when a vector has at most one bit set
// The helpers work on a fixed maximum width (MAX_W). Callers zero-extend
// narrower vectors, so any WIDTH up to MAX_W is supported.
// Build option: ZION_BITMAP_SER_MSB_FIRST_EN (used by the pick sub-module).
// ---------------------------------------------------------------------------
package zion_bitmap_ser_pkg;

    localparam int MAX_W     = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ser_state_e;

    // OR together the positions of all set bits; for a true one-hot input
    // this is exactly the index, and for zero it is zero.
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_W-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    function automatic logic popcnt_le1(input logic [MAX_W-1:0] v);
        return (v & (v - MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/zion_bitmap_pick_onehot.sv
// ---------------------------------------------------------------------------
// Module: zion_bitmap_pick_onehot
// Purpose: Combinational pick of the next set bit of a bitmap.
//   Default build : lowest set bit first.
//   ZION_BITMAP_SER_MSB_FIRST_EN defined : highest set bit first.
// Ports:
//   bitmap_i  in  WIDTH  bitmap to pick from (may be zero)
//   onehot_o  out WIDTH  one-hot of the picked bit (zero if bitmap_i is zero)
//   idx_o     out IDX_W  binary index of the picked bit (zero if none)
//   last_o    out 1      bitmap_i has exactly one bit set
// WIDTH must be in 2..MAX_W (see zion_bitmap_ser_pkg).
// ---------------------------------------------------------------------------
module zion_bitmap_pick_onehot
    import zion_bitmap_ser_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] bitmap_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    // The picker always isolates the lowest set bit of scan; the MSB-first
    // build just reverses the bit order on the way in and out.
    logic [WIDTH-1:0] scan;
    logic [WIDTH-1:0] scan_oh;

`ifdef ZION_BITMAP_SER_MSB_FIRST_EN
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign scan[gi]     = bitmap_i[WIDTH-1-gi];
            assign onehot_o[gi] = scan_oh[WIDTH-1-gi];
        end
    endgenerate
`else
    assign scan     = bitmap_i;
    assign onehot_o = scan_oh;
`endif

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign scan_oh = scan & (~scan + WIDTH'(1));

    assign idx_o  = IDX_W'(onehot2idx(MAX_W'(onehot_o)));
    assign last_o = (|bitmap_i) & popcnt_le1(MAX_W'(bitmap_i));

endmodule

// File: rtl/zion_bitmap_onehot_serializer.sv
// ---------------------------------------------------------------------------
// Module: zion_bitmap_onehot_serializer
// Purpose: Accepts a multi-hot bitmap and emits its set bits one per beat as a
//   one-hot vector plus binary index, with valid/ready on both sides.
// Ports:
//   iClk     in   1      clock
//   iRst_n   in   1      asynchronous active-low reset
//   iVld     in   1      input bitmap valid
//   oRdy     out  1      block can accept a bitmap
//   iBitmap  in   WIDTH  multi-hot bitmap to serialize
//   oVld     out  1      output beat valid
//   iRdy     in   1      downstream ready
//   oOnehot  out  WIDTH  one-hot of the current bit
//   oIdx     out  IDX_W  binary index of the current bit
//   oLast    out  1      current beat is the last set bit of the bitmap
// Build option: ZION_BITMAP_SER_MSB_FIRST_EN selects highest-index-first
//   emission (default lowest-index-first); handshake timing is identical.
// ---------------------------------------------------------------------------
module zion_bitmap_onehot_serializer
    import zion_bitmap_ser_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iBitmap,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oOnehot,
    output logic [IDX_W-1:0] oIdx,
    output logic             oLast
);

    ser_state_e       state_q,   state_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic             vld_q;
    logic [WIDTH-1:0] onehot_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;

    logic             accept;
    logic             retire;
    logic [WIDTH-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_last;

    // Ready in IDLE, or while the final beat of the current bitmap retires so
    // the next bitmap loads without a bubble.
    assign oRdy   = (state_q == ST_IDLE) | (vld_q & iRdy & last_q);
    assign accept = iVld & oRdy;
    assign retire = vld_q & iRdy;

    // Accept can only coincide with retire on the last beat, where the
    // cleared residue is zero anyway, so the new bitmap simply replaces it.
    // A zero bitmap loads zero residue, i.e. it is consumed with no beat.
    always_comb begin
        residue_d = residue_q;
        if (accept) begin
            residue_d = iBitmap;
        end else if (retire) begin
            residue_d = residue_q & ~onehot_q;
        end
    end

    assign state_d = (|residue_d) ? ST_BUSY : ST_IDLE;

    // Outputs are registered from the next residue, so they change only when
    // the residue changes and are held stable under backpressure.
    zion_bitmap_pick_onehot #(
        .WIDTH (WIDTH)
    ) u_pick (
        .bitmap_i (residue_d),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .last_o   (pick_last)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            residue_q <= '0;
            vld_q     <= 1'b0;
            onehot_q  <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            vld_q     <= |residue_d;
            onehot_q  <= pick_onehot;
            idx_q     <= pick_idx;
            last_q    <= pick_last;
        end
    end

    assign oVld    = vld_q;
    assign oOnehot = onehot_q;
    assign oIdx    = idx_q;
    assign oLast   = last_q;

endmodule
